// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - IITB-RISC memory stage: EX/M fields -> data memory req/ack -> M/WB register
// Two-state FSM holds the upstream stage while a load/store is outstanding, with timeout and flush kill.
module mem_access_stage #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] PC_plus2_in,
    input  logic [2:0]        WB_in,
    input  logic [1:0]        Memory_in,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [DATA_W-1:0] Memory_data_write_in,
    input  logic [DATA_W-1:0] Zero_pad_in,
    input  logic [2:0]        Dest_in,
    input  logic              Valid_in,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic [DATA_W-1:0] PC_plus2_out,
    output logic [2:0]        WB_out,
    output logic [DATA_W-1:0] ALU_out,
    output logic [DATA_W-1:0] Mem_data_out,
    output logic [DATA_W-1:0] Zero_pad_out,
    output logic [2:0]        Dest_out,
    output logic              Valid_out,
    output logic              illegal_op,
    output logic              mem_timeout
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt;
    logic              kill;
    logic              lat_load;
    logic [DATA_W-1:0] lat_pc;
    logic [DATA_W-1:0] lat_alu;
    logic [DATA_W-1:0] lat_zp;
    logic [2:0]        lat_wb;
    logic [2:0]        lat_dest;
    logic              is_mem_op;
    logic              issue;
    logic              ack_done;
    logic              tmo_done;

    assign is_mem_op = (Memory_in == 2'b10) || (Memory_in == 2'b01);
    assign issue     = (state == S_IDLE) && Valid_in && !flush && is_mem_op;
    assign ack_done  = (state == S_WAIT) && mem_ack;
    assign tmo_done  = (state == S_WAIT) && !mem_ack && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nx  = S_WAIT;
                    stall_out = 1'b1;
                end
            end
            // Timeout also releases the hold so EX/M does not re-present the expired op.
            S_WAIT: begin
                if (ack_done || tmo_done) begin
                    state_nx = S_IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (reset) begin
            stall_out = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            PC_plus2_out <= '0;
            WB_out       <= '0;
            ALU_out      <= '0;
            Mem_data_out <= '0;
            Zero_pad_out <= '0;
            Dest_out     <= '0;
            Valid_out    <= 1'b0;
            illegal_op   <= 1'b0;
            mem_timeout  <= 1'b0;
            cnt          <= '0;
            kill         <= 1'b0;
            lat_load     <= 1'b0;
            lat_pc       <= '0;
            lat_alu      <= '0;
            lat_zp       <= '0;
            lat_wb       <= '0;
            lat_dest     <= '0;
        end else begin
            Valid_out  <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Valid_in) begin
                        if (Memory_in == 2'b11) begin
                            illegal_op <= 1'b1;
                        end else if (issue) begin
                            mem_req   <= 1'b1;
                            mem_we    <= Memory_in[0];
                            mem_addr  <= ALU_in;
                            mem_wdata <= Memory_data_write_in;
                            lat_load  <= Memory_in[1];
                            lat_pc    <= PC_plus2_in;
                            lat_alu   <= ALU_in;
                            lat_zp    <= Zero_pad_in;
                            lat_wb    <= WB_in;
                            lat_dest  <= Dest_in;
                            cnt       <= '0;
                            kill      <= 1'b0;
                        end else if (Memory_in == 2'b00) begin
                            PC_plus2_out <= PC_plus2_in;
                            WB_out       <= WB_in;
                            ALU_out      <= ALU_in;
                            Mem_data_out <= '0;
                            Zero_pad_out <= Zero_pad_in;
                            Dest_out     <= Dest_in;
                            Valid_out    <= !flush;
                        end
                    end
                end
                S_WAIT: begin
                    if (ack_done || tmo_done) begin
                        mem_req      <= 1'b0;
                        cnt          <= '0;
                        kill         <= 1'b0;
                        PC_plus2_out <= lat_pc;
                        WB_out       <= lat_wb;
                        ALU_out      <= lat_alu;
                        Zero_pad_out <= lat_zp;
                        Dest_out     <= lat_dest;
                        if (ack_done) begin
                            Mem_data_out <= lat_load ? mem_rdata : '0;
                            Valid_out    <= !kill && !flush;
                        end else begin
                            Mem_data_out <= '1;
                            mem_timeout  <= 1'b1;
                        end
                    end else begin
                        // A flush cannot abort the bus cycle; remember it and drop the result.
                        cnt  <= cnt + 8'd1;
                        kill <= kill | flush;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - table-driven and randomized checks of mem_access_stage
module tb_mem_access_stage;
    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] PC_plus2_in, ALU_in, Memory_data_write_in, Zero_pad_in, mem_rdata;
    logic [2:0]  WB_in, Dest_in;
    logic [1:0]  Memory_in;
    logic        Valid_in, flush, mem_ack;
    logic        mem_req, mem_we, stall_out, Valid_out, illegal_op, mem_timeout;
    logic [15:0] mem_addr, mem_wdata, PC_plus2_out, ALU_out, Mem_data_out, Zero_pad_out;
    logic [2:0]  WB_out, Dest_out;

    mem_access_stage #(.DATA_W(16), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .PC_plus2_in(PC_plus2_in), .WB_in(WB_in), .Memory_in(Memory_in), .ALU_in(ALU_in),
        .Memory_data_write_in(Memory_data_write_in), .Zero_pad_in(Zero_pad_in),
        .Dest_in(Dest_in), .Valid_in(Valid_in), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
        .PC_plus2_out(PC_plus2_out), .WB_out(WB_out), .ALU_out(ALU_out),
        .Mem_data_out(Mem_data_out), .Zero_pad_out(Zero_pad_out), .Dest_out(Dest_out),
        .Valid_out(Valid_out), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  mem;
        logic [15:0] alu, wdata, rdata, pc, zp;
        logic [2:0]  wb, dest;
        int          ack_at;    // WAIT cycle carrying mem_ack, 0 = never
        int          flush_at;  // -1 none, 0 in the issue cycle, k in WAIT cycle k
    } op_t;

    typedef struct {
        logic        valid;
        logic [15:0] mdata;
        int          busy;      // cycles with stall_out high == WAIT cycles with mem_req high
        logic        illegal;
        logic        tmo;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t want;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[11];
    op_t  rop;
    exp_t rexp;
    logic tmo_model;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s.%s: actual %0h required %0h", tag, name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic op_t mk_op(logic [1:0] mem, logic [15:0] alu, logic [15:0] wdata,
                                  logic [15:0] rdata, logic [2:0] dest, int ack_at, int flush_at);
        op_t o;
        o.mem = mem; o.alu = alu; o.wdata = wdata; o.rdata = rdata; o.dest = dest;
        o.ack_at = ack_at; o.flush_at = flush_at;
        o.pc = 16'($urandom); o.wb = 3'($urandom); o.zp = 16'($urandom);
        return o;
    endfunction

    function automatic exp_t mk_exp(logic valid, logic [15:0] mdata, int busy, logic illegal, logic tmo);
        exp_t e;
        e.valid = valid; e.mdata = mdata; e.busy = busy; e.illegal = illegal; e.tmo = tmo;
        return e;
    endfunction

    // Transaction-level reference: what one instruction should produce, given the memory's behaviour.
    function automatic exp_t predict(op_t op, logic tmo_in);
        exp_t e;
        bit   acked;
        int   last;
        e = mk_exp(1'b0, 16'h0000, 0, op.mem == 2'b11, tmo_in);
        if (op.mem == 2'b00) begin
            e.valid = (op.flush_at != 0);
        end else if (op.mem != 2'b11 && op.flush_at != 0) begin
            acked   = (op.ack_at >= 1) && (op.ack_at <= TMO);
            last    = acked ? op.ack_at : TMO;
            e.busy  = last;
            e.valid = acked && !(op.flush_at >= 1 && op.flush_at <= last);
            e.mdata = !acked ? 16'hFFFF : (op.mem[1] ? op.rdata : 16'h0000);
            e.tmo   = tmo_in | !acked;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input op_t op, input exp_t e);
        int stalls;
        int reqs;
        bit hold_bad;
        bit completes;
        completes = (op.mem == 2'b00) || (e.busy > 0);
        Valid_in = 1'b1; Memory_in = op.mem; ALU_in = op.alu; Memory_data_write_in = op.wdata;
        PC_plus2_in = op.pc; WB_in = op.wb; Zero_pad_in = op.zp; Dest_in = op.dest;
        flush = (op.flush_at == 0); mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        #1;
        stalls = stall_out ? 1 : 0;
        reqs = 0;
        hold_bad = 1'b0;
        step();
        flush = 1'b0;
        if (e.busy > 0) begin
            chk(tag, "issue_req", 32'(mem_req), 32'(1'b1));
            chk(tag, "issue_we", 32'(mem_we), 32'(op.mem[0]));
            chk(tag, "issue_addr", 32'(mem_addr), 32'(op.alu));
            chk(tag, "issue_wdata", 32'(mem_wdata), 32'(op.wdata));
            chk(tag, "bubble", 32'(Valid_out), 32'(1'b0));
            for (int k = 1; k <= e.busy; k++) begin
                flush = (op.flush_at == k);
                mem_ack = (op.ack_at == k);
                mem_rdata = mem_ack ? op.rdata : 16'hDEAD;
                #1;
                if (stall_out) stalls++;
                if (mem_req) reqs++;
                if (mem_we !== op.mem[0] || mem_addr !== op.alu || mem_wdata !== op.wdata) hold_bad = 1'b1;
                step();
            end
            flush = 1'b0;
            mem_ack = 1'b0;
            chk(tag, "req_cycles", 32'(reqs), 32'(e.busy));
            chk(tag, "req_hold", 32'(hold_bad), 32'(1'b0));
            chk(tag, "req_drop", 32'(mem_req), 32'(1'b0));
        end else begin
            chk(tag, "no_req", 32'(mem_req), 32'(1'b0));
        end
        chk(tag, "stall_cycles", 32'(stalls), 32'(e.busy));
        chk(tag, "valid", 32'(Valid_out), 32'(e.valid));
        chk(tag, "illegal", 32'(illegal_op), 32'(e.illegal));
        chk(tag, "timeout", 32'(mem_timeout), 32'(e.tmo));
        if (completes) begin
            chk(tag, "mem_data", 32'(Mem_data_out), 32'(e.mdata));
            chk(tag, "alu_out", 32'(ALU_out), 32'(op.alu));
            chk(tag, "pc_out", 32'(PC_plus2_out), 32'(op.pc));
            chk(tag, "wb_out", 32'(WB_out), 32'(op.wb));
            chk(tag, "zp_out", 32'(Zero_pad_out), 32'(op.zp));
            chk(tag, "dest_out", 32'(Dest_out), 32'(op.dest));
        end
        if (e.illegal) begin
            Valid_in = 1'b0;
            step();
            chk(tag, "illegal_pulse", 32'(illegal_op), 32'(1'b0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Valid_in = 1'b1; Memory_in = 2'b10; flush = 1'b0; mem_ack = 1'b0;
        mem_rdata = 16'h0; PC_plus2_in = 16'h0; ALU_in = 16'h0; Memory_data_write_in = 16'h0;
        Zero_pad_in = 16'h0; WB_in = 3'd0; Dest_in = 3'd0;
        step();
        step();
        chk("reset", "valid", 32'(Valid_out), 32'(1'b0));
        chk("reset", "req", 32'(mem_req), 32'(1'b0));
        chk("reset", "stall", 32'(stall_out), 32'(1'b0));
        chk("reset", "timeout", 32'(mem_timeout), 32'(1'b0));
        chk("reset", "illegal", 32'(illegal_op), 32'(1'b0));
        chk("reset", "alu_out", 32'(ALU_out), 32'(16'h0));
        reset = 1'b0;
        Valid_in = 1'b0;
        step();

        tbl[0]  = '{mk_op(2'b00, 16'h1234, 16'h0000, 16'h0000, 3'd3, 0, -1), mk_exp(1'b1, 16'h0000, 0, 1'b0, 1'b0)};
        tbl[1]  = '{mk_op(2'b10, 16'h0040, 16'h0000, 16'hBEEF, 3'd1, 4, -1), mk_exp(1'b1, 16'hBEEF, 4, 1'b0, 1'b0)};
        tbl[2]  = '{mk_op(2'b01, 16'h0010, 16'h00AA, 16'h0000, 3'd0, 1, -1), mk_exp(1'b1, 16'h0000, 1, 1'b0, 1'b0)};
        tbl[3]  = '{mk_op(2'b10, 16'h0080, 16'h0000, 16'h1111, 3'd2, 4, 2),  mk_exp(1'b0, 16'h1111, 4, 1'b0, 1'b0)};
        tbl[4]  = '{mk_op(2'b00, 16'h5555, 16'h0000, 16'h0000, 3'd4, 0, 0),  mk_exp(1'b0, 16'h0000, 0, 1'b0, 1'b0)};
        tbl[5]  = '{mk_op(2'b01, 16'h0020, 16'h0033, 16'h0000, 3'd5, 1, 0),  mk_exp(1'b0, 16'h0000, 0, 1'b0, 1'b0)};
        tbl[6]  = '{mk_op(2'b11, 16'h0030, 16'h0000, 16'h0000, 3'd6, 0, -1), mk_exp(1'b0, 16'h0000, 0, 1'b1, 1'b0)};
        tbl[7]  = '{mk_op(2'b10, 16'h0050, 16'h0000, 16'h2222, 3'd7, 0, -1), mk_exp(1'b0, 16'hFFFF, 4, 1'b0, 1'b1)};
        tbl[8]  = '{mk_op(2'b00, 16'h0A0A, 16'h0000, 16'h0000, 3'd1, 0, -1), mk_exp(1'b1, 16'h0000, 0, 1'b0, 1'b1)};
        tbl[9]  = '{mk_op(2'b10, 16'h0060, 16'h0000, 16'h3333, 3'd2, 2, 2),  mk_exp(1'b0, 16'h3333, 2, 1'b0, 1'b1)};
        tbl[10] = '{mk_op(2'b01, 16'h0070, 16'h0044, 16'h0000, 3'd3, 6, -1), mk_exp(1'b0, 16'hFFFF, 4, 1'b0, 1'b1)};
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].want);
        end

        // Reset in the middle of a load, then a stray ack while IDLE.
        Valid_in = 1'b1; Memory_in = 2'b10; ALU_in = 16'h0100; flush = 1'b0; mem_ack = 1'b0;
        #1;
        step();
        step();
        chk("rst_wait", "pre_req", 32'(mem_req), 32'(1'b1));
        #2 reset = 1'b1;
        #1;
        chk("rst_wait", "req", 32'(mem_req), 32'(1'b0));
        chk("rst_wait", "stall", 32'(stall_out), 32'(1'b0));
        chk("rst_wait", "valid", 32'(Valid_out), 32'(1'b0));
        chk("rst_wait", "timeout", 32'(mem_timeout), 32'(1'b0));
        chk("rst_wait", "alu_out", 32'(ALU_out), 32'(16'h0));
        chk("rst_wait", "addr", 32'(mem_addr), 32'(16'h0));
        chk("rst_wait", "pc_out", 32'(PC_plus2_out), 32'(16'h0));
        step();
        reset = 1'b0; Valid_in = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h4321;
        #1;
        chk("late_ack", "stall", 32'(stall_out), 32'(1'b0));
        step();
        mem_ack = 1'b0;
        chk("late_ack", "valid", 32'(Valid_out), 32'(1'b0));
        chk("late_ack", "req", 32'(mem_req), 32'(1'b0));
        chk("late_ack", "mem_data", 32'(Mem_data_out), 32'(16'h0));

        tmo_model = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rop = mk_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
                        3'($urandom), int'($urandom_range(0, 6)), -1);
            if ($urandom_range(0, 3) == 0) rop.flush_at = int'($urandom_range(0, 5));
            rexp = predict(rop, tmo_model);
            tmo_model = rexp.tmo;
            run_op($sformatf("rnd%0d", i), rop, rexp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
